// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Groups the pipeline-side and memory-side signals of the data memory
// controller into one bundle.
//   Pipeline side : mem_read, mem_write, funct3, addr, wdata  -> controller
//                   rdata, stall, fault, bus_err              <- controller
//   Memory side   : m_req, m_we, m_addr, m_wdata, m_be        <- controller
//                   m_ack, m_rdata                            -> controller
// The slave modport is the controller; the master modport is whoever drives
// the pipeline requests and answers as the memory.
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata, m_ack, m_rdata,
    output rdata, stall, fault, bus_err, m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output mem_read, mem_write, funct3, addr, wdata, m_ack, m_rdata,
    input  rdata, stall, fault, bus_err, m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Load/store unit between the MEM pipeline stage and a word-wide memory with
// an ack handshake. Classifies each access, formats store lanes/byte enables,
// formats load data, stalls the pipeline while the memory is busy and times
// out after 255 wait cycles.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - data_mem_ctrl_if.slave (pipeline request/response + memory bus)
// ---------------------------------------------------------------------------
module data_mem_ctrl (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_be_q, m_be_d;
  logic        m_we_q, m_we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  wait_q, wait_d;
  logic        fault_q, fault_d;
  logic        bus_err_q, bus_err_d;
  logic        stall_s;
  logic        access_s;
  logic        ok_s;

  // Stores accept byte/half/word; loads additionally accept the unsigned forms.
  function automatic logic funct3_legal(input logic is_wr, input logic [2:0] f3);
    logic r;
    case (f3)
      3'b000, 3'b001, 3'b010: r = 1'b1;
      3'b100, 3'b101:         r = ~is_wr;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3[1:0])
      2'b01:   r = lo[0];
      2'b10:   r = (lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Replicate the store operand across lanes so the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << lo;
      2'b01:   r = lo[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      2'b11:   b = d[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign access_s = bus.mem_read | bus.mem_write;
  // A simultaneous read+write is treated as the write.
  assign ok_s     = funct3_legal(bus.mem_write, bus.funct3) & ~misaligned(bus.funct3, bus.addr[1:0]);

  // Next-state and combinational outputs for the access sequencer.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    m_we_d    = m_we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    wait_d    = wait_q;
    fault_d   = 1'b0;
    bus_err_d = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          if (ok_s) begin
            stall_s   = 1'b1;
            m_addr_d  = {bus.addr[31:2], 2'b00};
            m_we_d    = bus.mem_write;
            m_wdata_d = bus.mem_write ? store_data(bus.funct3, bus.wdata) : 32'h0000_0000;
            m_be_d    = access_be(bus.funct3, bus.addr[1:0]);
            funct3_d  = bus.funct3;
            addr_lo_d = bus.addr[1:0];
            wait_d    = 8'd0;
            state_d   = BUSY;
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (bus.m_ack) begin
          if (!m_we_q) begin
            rdata_d = load_format(funct3_q, addr_lo_q, bus.m_rdata);
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else if (wait_q == 8'd254) begin
          // This cycle is the 255th without ack: give up.
          wait_d    = 8'd255;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rdata_q   <= 32'h0000_0000;
      m_addr_q  <= 32'h0000_0000;
      m_wdata_q <= 32'h0000_0000;
      m_be_q    <= 4'b0000;
      m_we_q    <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      wait_q    <= 8'd0;
      fault_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      m_we_q    <= m_we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Stall is combinational in the detect cycle, so gate it with reset to make
  // it drop the moment reset is asserted even while a request is presented.
  assign bus.stall   = stall_s & ~reset;
  assign bus.m_req   = (state_q == BUSY);
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_be    = m_be_q;
  assign bus.rdata   = rdata_q;
  assign bus.fault   = fault_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Drives directed and random loads/stores, plays the memory, and compares
// every cycle against a transaction-timeline model of the controller.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;
  logic clk;
  logic reset;
  data_mem_ctrl_if bus ();

  data_mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle outputs
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_mreq = 1'b0, exp_fault = 1'b0, exp_buserr = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        exp_we = 1'b0;

  // Observation counters
  int          stall_cnt = 0, mreq_cnt = 0, fault_cnt = 0, berr_cnt = 0;
  logic [31:0] last_maddr = 32'h0, last_mwdata = 32'h0;
  logic [3:0]  last_mbe = 4'h0;
  logic        last_mwe = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Load result from byte address, size and signedness using plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] d);
    int          size;
    logic [31:0] v;
    logic [31:0] mask;
    size = 1 << f3[1:0];
    if (size >= 4) return d;
    v    = d >> (8 * lo);
    mask = (32'd1 << (8 * size)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.stall)   stall_cnt <= stall_cnt + 1;
    if (bus.m_req)   mreq_cnt  <= mreq_cnt + 1;
    if (bus.fault)   fault_cnt <= fault_cnt + 1;
    if (bus.bus_err) berr_cnt  <= berr_cnt + 1;
    if (bus.m_req) begin
      last_maddr  <= bus.m_addr;
      last_mwdata <= bus.m_wdata;
      last_mbe    <= bus.m_be;
      last_mwe    <= bus.m_we;
    end
    if (chk_en) begin
      check("stall",   {31'd0, bus.stall},   {31'd0, exp_stall});
      check("m_req",   {31'd0, bus.m_req},   {31'd0, exp_mreq});
      check("fault",   {31'd0, bus.fault},   {31'd0, exp_fault});
      check("bus_err", {31'd0, bus.bus_err}, {31'd0, exp_buserr});
      check("rdata",   bus.rdata,            exp_rdata);
      if (exp_mreq) begin
        check("m_addr", bus.m_addr,         exp_addr);
        check("m_we",   {31'd0, bus.m_we},  {31'd0, exp_we});
        if (exp_we) begin
          check("m_wdata", bus.m_wdata,       exp_wdata);
          check("m_be",    {28'd0, bus.m_be}, {28'd0, exp_be});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      bus.funct3    = 3'($urandom);
      bus.m_ack     = 1'($urandom);
      bus.m_rdata   = $urandom;
      exp_stall = 1'b0; exp_mreq = 1'b0; exp_fault = 1'b0; exp_buserr = 1'b0;
    end
  endtask

  // delay < 0 means the memory never acks.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int delay, input logic [31:0] mrd);
    int   size;
    int   nbusy;
    logic legal, mis, tmo;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (a & 32'(size - 1)) != 32'd0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_we   = wr;
    exp_be   = 4'(((1 << size) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];

    @(posedge clk); #1;
    bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    bus.m_ack = 1'($urandom); bus.m_rdata = $urandom;
    exp_stall = legal && !mis; exp_mreq = 1'b0; exp_fault = 1'b0; exp_buserr = 1'b0;
    if (!(legal && !mis)) begin
      @(posedge clk); #1;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.m_ack = 1'($urandom);
      exp_stall = 1'b0; exp_fault = 1'b1;
      return;
    end
    tmo   = (delay < 0);
    nbusy = tmo ? 255 : delay + 1;
    for (int k = 1; k <= nbusy; k++) begin
      @(posedge clk); #1;
      bus.addr = $urandom; bus.wdata = $urandom; bus.funct3 = 3'($urandom);
      bus.m_ack   = (!tmo && k == nbusy);
      bus.m_rdata = bus.m_ack ? mrd : $urandom;
      exp_stall = 1'b1; exp_mreq = 1'b1; exp_fault = 1'b0;
    end
    @(posedge clk); #1;
    bus.m_ack = 1'($urandom); bus.m_rdata = $urandom;
    exp_stall = 1'b0; exp_mreq = 1'b0; exp_buserr = tmo;
    if (!wr && !tmo) exp_rdata = model_load(f3, a[1:0], mrd);
  endtask

  int s0, m0, f0, b0;

  initial begin
    reset = 1'b1;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h0;
    bus.wdata = 32'h0; bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    repeat (2) @(posedge clk); #1;
    check("rst_stall",   {31'd0, bus.stall},   32'd0);
    check("rst_m_req",   {31'd0, bus.m_req},   32'd0);
    check("rst_m_we",    {31'd0, bus.m_we},    32'd0);
    check("rst_fault",   {31'd0, bus.fault},   32'd0);
    check("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    check("rst_rdata",   bus.rdata,            32'd0);
    check("rst_m_addr",  bus.m_addr,           32'd0);
    check("rst_m_wdata", bus.m_wdata,          32'd0);
    check("rst_m_be",    {28'd0, bus.m_be},    32'd0);
    reset = 1'b0; bus.mem_read = 1'b0; chk_en = 1'b1;
    idle(2);

    // LB, zero-wait memory
    s0 = stall_cnt;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FF12);
    idle(2);
    check("lb_rdata",  bus.rdata, 32'hFFFF_FF80);
    check("lb_m_addr", last_maddr, 32'h100);
    check("lb_stall_cycles", 32'(stall_cnt - s0), 32'd2);

    // SH, upper half
    run_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 2, 32'h0);
    idle(2);
    check("sh_m_we",    {31'd0, last_mwe}, 32'd1);
    check("sh_m_be",    {28'd0, last_mbe}, 32'hC);
    check("sh_m_wdata", last_mwdata,       32'hABCD_ABCD);
    check("sh_m_addr",  last_maddr,        32'h20);

    // Misaligned LW
    s0 = stall_cnt; m0 = mreq_cnt; f0 = fault_cnt;
    run_access(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 0, 32'h0);
    idle(2);
    check("lw_mis_fault_cycles", 32'(fault_cnt - f0), 32'd1);
    check("lw_mis_m_req_cycles", 32'(mreq_cnt - m0),  32'd0);
    check("lw_mis_stall_cycles", 32'(stall_cnt - s0), 32'd0);

    // Load that is never acked
    s0 = stall_cnt; m0 = mreq_cnt; b0 = berr_cnt;
    run_access(1'b1, 1'b0, 3'b100, 32'h44, 32'h0, -1, 32'h0);
    idle(2);
    check("tmo_busy_cycles",    32'(mreq_cnt - m0),  32'd255);
    check("tmo_stall_cycles",   32'(stall_cnt - s0), 32'd256);
    check("tmo_bus_err_cycles", 32'(berr_cnt - b0),  32'd1);
    check("tmo_rdata_kept",     bus.rdata,           32'hFFFF_FF80);

    // Reset in the third BUSY cycle
    exp_addr = 32'h10; exp_we = 1'b0;
    @(posedge clk); #1;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h10;
    bus.m_ack = 1'b0;
    exp_stall = 1'b1; exp_mreq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.m_ack = 1'b0; exp_stall = 1'b1; exp_mreq = 1'b1;
    end
    #2; chk_en = 1'b0; reset = 1'b1; #1;
    check("midrst_m_req",  {31'd0, bus.m_req}, 32'd0);
    check("midrst_stall",  {31'd0, bus.stall}, 32'd0);
    check("midrst_rdata",  bus.rdata,          32'd0);
    check("midrst_m_addr", bus.m_addr,         32'd0);
    check("midrst_m_be",   {28'd0, bus.m_be},  32'd0);
    @(posedge clk); #1;
    bus.mem_read = 1'b0; reset = 1'b0;
    exp_rdata = 32'h0; exp_stall = 1'b0; exp_mreq = 1'b0; exp_fault = 1'b0; exp_buserr = 1'b0;
    chk_en = 1'b1;
    run_access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 0, 32'h8001_0000);
    idle(2);
    check("lhu_rdata", bus.rdata, 32'h0000_8001);

    // Read and write together: the write wins
    run_access(1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 1, $urandom);
    idle(2);
    check("rw_m_be",    {28'd0, last_mbe}, 32'hF);
    check("rw_m_we",    {31'd0, last_mwe}, 32'd1);
    check("rw_m_wdata", last_mwdata,       32'hDEAD_BEEF);
    check("rw_m_addr",  last_maddr,        32'h40);
    check("rw_rdata",   bus.rdata,         32'h0000_8001);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      int          sel, dly;
      logic        rd, wr;
      sel = $urandom_range(0, 3);
      rd  = (sel != 2);
      wr  = (sel >= 2);
      dly = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 5);
      run_access(rd, wr, 3'($urandom), $urandom, $urandom, dly, $urandom);
      idle($urandom_range(1, 3));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and use an asynchronous, active-high reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port mem_read, input, 1 bit: load request from the MEM stage.
REQ-005 The block SHALL have port mem_write, input, 1 bit: store request from the MEM stage.
REQ-006 The block SHALL have port funct3, input, 3 bits: access size and signedness.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address from the ALU.
REQ-008 The block SHALL have port wdata, input, 32 bits: store data from rs2.
REQ-009 The block SHALL have the following output ports:
- rdata, 32 bits: formatted load result.
- stall, 1 bit: holds the pipeline.
- fault, 1 bit: misaligned or illegal access.
- bus_err, 1 bit: memory timeout.
REQ-010 The block SHALL have memory-side ports:
- m_req, output, 1 bit: request.
- m_we, output, 1 bit: write enable.
- m_addr, output, 32 bits: word-aligned address, bits [1:0] = 0.
- m_wdata, output, 32 bits: write data.
- m_be, output, 4 bits: byte enables.
- m_ack, input, 1 bit: completion.
- m_rdata, input, 32 bits: read data.

Function
REQ-011 The block SHALL implement the states IDLE, BUSY and DONE.
REQ-012 In IDLE with mem_read or mem_write set, the block SHALL classify the access:
- Legal funct3 values are 000, 001 and 010 for stores, plus 100 and 101 for loads.
- Any other value is illegal.
- Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 00.
REQ-013 For an illegal or misaligned access, the block SHALL:
- Pulse fault for 1 cycle.
- Issue no m_req.
- Keep stall at 0.
- Remain in IDLE.
REQ-014 For a legal aligned access, the block SHALL:
- Assert stall combinationally in that same cycle.
- Latch addr, funct3, wdata and the write flag.
- Enter BUSY.
REQ-015 If mem_read and mem_write are both 1, the block SHALL perform the write and ignore the read.
REQ-016 In BUSY, the block SHALL:
- Hold m_req = 1 and stall = 1.
- Keep m_addr, m_we, m_wdata and m_be stable until m_ack.
REQ-017 On m_ack in BUSY, the block SHALL:
- Drop m_req on the next edge.
- For a load, register the formatted m_rdata into rdata.
- Enter DONE.
REQ-018 In DONE, the block SHALL:
- Drive stall = 0.
- Ignore mem_read and mem_write.
- Return to IDLE on the next edge.
- Hold rdata until the next load completes.
REQ-019 With zero-wait memory (m_ack high in the first BUSY cycle), the minimum access latency SHALL be 2 stall cycles (IDLE detect + BUSY) followed by DONE.
REQ-020 Load formatting SHALL select data by latched addr[1:0]:
- LB (000) sign-extends the selected byte.
- LBU (100) zero-extends the selected byte.
- LH (001) sign-extends the selected halfword, chosen by addr[1].
- LHU (101) zero-extends the selected halfword.
- LW (010) passes all 32 bits through.
REQ-021 Store formatting SHALL be:
- SB: byte replicated to all four lanes, m_be = 0001 shifted left by addr[1:0].
- SH: halfword replicated to both halves, m_be = 0011 or 1100 by addr[1].
- SW: m_be = 1111.
REQ-022 In BUSY, an 8-bit wait counter SHALL increment each cycle without m_ack.
REQ-023 When the wait counter reaches 255, the block SHALL:
- Pulse bus_err for 1 cycle.
- Drop m_req.
- Leave rdata unchanged.
- Enter DONE.
REQ-024 m_ack arriving outside BUSY SHALL be ignored.

Reset
REQ-025 Asserting reset at any time, including mid-BUSY, SHALL immediately force:
- State to IDLE.
- stall, m_req, m_we, fault and bus_err to 0.
- rdata, m_addr, m_wdata and the wait counter to 0.
- m_be to 0000.
REQ-026 After reset is released, the first rising edge SHALL evaluate inputs normally.

Verification
REQ-027 The bench SHALL check an LB with addr = 0x103 and m_rdata = 0x80FF_FF_12, acked in the first BUSY cycle -> m_addr = 0x100, rdata = 0xFFFFFF80, stall high exactly 2 cycles.
REQ-028 The bench SHALL check an SH with addr = 0x22 and wdata = 0x0000ABCD -> m_we = 1, m_be = 1100, m_wdata = 0xABCDABCD, m_addr = 0x20.
REQ-029 The bench SHALL check an LW with addr = 0x06 -> fault pulses 1 cycle, no m_req, stall stays 0.
REQ-030 The bench SHALL check a load with m_ack never asserted -> bus_err pulses after 255 BUSY cycles, then DONE, stall drops.
REQ-031 The bench SHALL check reset asserted in the 3rd BUSY cycle -> m_req and stall go to 0 immediately, and a following LHU at addr 0x2, m_rdata = 0x8001_0000, yields rdata = 0x00008001.
REQ-032 The bench SHALL check mem_read = mem_write = 1 with SW at addr 0x40 -> write performed with m_be = 1111, rdata unchanged.
